// File: rtl/cpu_pkg.sv
// cpu_pkg -- constants shared by the fetch unit and the ALU.
//   Opcode byte values for the supported instruction subset, the fetch FSM
//   state encoding and the width of an instruction-length field.
package cpu_pkg;

    localparam int LEN_W = 4;

    localparam logic [7:0] OP_PUSH_EBP = 8'h55;  // push ebp
    localparam logic [7:0] OP_POP_EBP  = 8'h5d;  // pop ebp
    localparam logic [7:0] OP_RET      = 8'hc3;  // ret
    localparam logic [7:0] OP_MOV_RM_R = 8'h89;  // mov r/m32, r32
    localparam logic [7:0] OP_PUSH_I8  = 8'h6a;  // push imm8
    localparam logic [7:0] OP_LOOP     = 8'he2;  // loop rel8
    localparam logic [7:0] OP_MOV_R_RM = 8'h8b;  // mov r32, r/m32 (disp8)
    localparam logic [7:0] OP_GRP1_I8  = 8'h83;  // add/sub/cmp r/m32, imm8
    localparam logic [7:0] OP_MOV_I32  = 8'hb8;  // mov eax, imm32
    localparam logic [7:0] OP_CALL     = 8'he8;  // call rel32

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_FETCH_OP   = 2'd1,
        ST_FETCH_REST = 2'd2,
        ST_PRESENT    = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/inst_len_decode.sv
// inst_len_decode -- combinational opcode -> instruction length lookup.
//   i_opcode   : first instruction byte
//   o_len      : instruction length in bytes (1..5)
//   o_illegal  : opcode not in the table (length forced to 1)
module inst_len_decode
    import cpu_pkg::*;
(
    input  logic [7:0]       i_opcode,
    output logic [LEN_W-1:0] o_len,
    output logic             o_illegal
);

    always_comb begin
        o_len     = 4'd1;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_PUSH_EBP, OP_POP_EBP, OP_RET:      o_len = 4'd1;
            OP_MOV_RM_R, OP_PUSH_I8, OP_LOOP:     o_len = 4'd2;
            OP_MOV_R_RM, OP_GRP1_I8:              o_len = 4'd3;
            OP_MOV_I32, OP_CALL:                  o_len = 4'd5;
            default:                              o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch -- byte-serial instruction fetch unit.
//   Reads one byte per acked memory cycle starting at eip, decodes the length
//   from the first byte, and presents up to four bytes of the instruction
//   (a fifth byte is fetched but not kept) with its length and next_eip.
// Ports:
//   clock, reset_n              : clock, async active-low reset
//   mem_req/mem_addr            : byte read request and address
//   mem_ack/mem_data            : read completion and byte
//   ope/num_of_ope/next_eip     : presented instruction window, length, next pc
//   illegal                     : first byte not in the length table
//   ope_valid/ope_ready         : presentation handshake
//   eip_load/eip_load_value     : redirect, highest priority in every state
module inst_fetch
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [31:0] ope,
    output logic [3:0]  num_of_ope,
    output logic [31:0] next_eip,
    output logic        illegal,
    output logic        ope_valid,
    input  logic        ope_ready,
    input  logic        eip_load,
    input  logic [31:0] eip_load_value
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [31:0]      r_eip;
    logic [31:0]      r_ope;
    logic [LEN_W-1:0] r_num;
    logic [2:0]       r_cnt;      // bytes already fetched for this instruction
    logic             r_illegal;

    logic [LEN_W-1:0] w_len;
    logic             w_len_ill;
    logic             w_req;
    logic             w_vld;
    logic             w_take;     // a byte is accepted this cycle
    logic [2:0]       w_cnt_inc;
    logic [31:0]      w_next_eip;

    inst_len_decode u_len (
        .i_opcode  (mem_data),
        .o_len     (w_len),
        .o_illegal (w_len_ill)
    );

    assign w_cnt_inc  = r_cnt + 3'd1;
    assign w_next_eip = r_eip + {28'd0, r_num};
    // A redirect in the same cycle drops the byte; acks without a request
    // are ignored.
    assign w_take     = mem_ack & w_req & ~eip_load;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_vld       = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_FETCH_OP;
            ST_FETCH_OP: begin
                w_req = 1'b1;
                if (mem_ack)
                    w_state_nxt = (w_len == 4'd1) ? ST_PRESENT : ST_FETCH_REST;
            end
            ST_FETCH_REST: begin
                w_req = 1'b1;
                if (mem_ack && ({1'b0, w_cnt_inc} == r_num))
                    w_state_nxt = ST_PRESENT;
            end
            ST_PRESENT: begin
                w_vld = 1'b1;
                if (ope_ready)
                    w_state_nxt = ST_FETCH_OP;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Redirect passes through IDLE so mem_req and ope_valid are low for
        // one cycle before fetching resumes at the new target.
        if (eip_load)
            w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_eip     <= 32'd0;
            r_ope     <= 32'd0;
            r_num     <= '0;
            r_cnt     <= 3'd0;
            r_illegal <= 1'b0;
        end else if (eip_load) begin
            // Overrides a same-cycle accept: eip takes the target, not next_eip.
            r_eip <= eip_load_value;
            r_cnt <= 3'd0;
        end else begin
            case (r_state)
                ST_FETCH_OP: if (w_take) begin
                    r_ope     <= {mem_data, 24'h000000};  // clears unused lanes
                    r_num     <= w_len;
                    r_illegal <= w_len_ill;
                    r_cnt     <= 3'd1;
                end
                ST_FETCH_REST: if (w_take) begin
                    r_cnt <= w_cnt_inc;
                    case (r_cnt)
                        3'd1:    r_ope[23:16] <= mem_data;
                        3'd2:    r_ope[15:8]  <= mem_data;
                        3'd3:    r_ope[7:0]   <= mem_data;
                        default: ;                        // 5th byte not kept
                    endcase
                end
                ST_PRESENT: if (ope_ready) begin
                    r_eip <= w_next_eip;
                    r_cnt <= 3'd0;
                end
                default: ;
            endcase
        end
    end

    assign mem_req    = w_req;
    assign mem_addr   = r_eip + {29'd0, r_cnt};
    assign ope_valid  = w_vld;
    assign ope        = r_ope;
    assign num_of_ope = r_num;
    assign next_eip   = w_next_eip;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch -- directed bench for inst_fetch with a 256-byte memory
// model (indexed by mem_addr[7:0]) that acks combinationally while enabled.
module tb_inst_fetch;

    logic        clock;
    logic        reset_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [31:0] ope;
    logic [3:0]  num_of_ope;
    logic [31:0] next_eip;
    logic        illegal;
    logic        ope_valid;
    logic        ope_ready;
    logic        eip_load;
    logic [31:0] eip_load_value;

    logic [7:0]  mem [256];
    logic        ack_en;
    logic        ack_force;
    int          n_tests;
    int          n_fail;

    inst_fetch dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data),
        .ope            (ope),
        .num_of_ope     (num_of_ope),
        .next_eip       (next_eip),
        .illegal        (illegal),
        .ope_valid      (ope_valid),
        .ope_ready      (ope_ready),
        .eip_load       (eip_load),
        .eip_load_value (eip_load_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_ack  = ack_force | (ack_en & mem_req);
    assign mem_data = mem[mem_addr[7:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_instr(input string tag, input logic [31:0] e_ope,
                             input logic [3:0] e_num, input logic [31:0] e_next,
                             input logic e_ill);
        chk({tag, ".valid"}, {31'd0, ope_valid}, 32'd1);
        chk({tag, ".ope"},   ope, e_ope);
        chk({tag, ".num"},   {28'd0, num_of_ope}, {28'd0, e_num});
        chk({tag, ".next"},  next_eip, e_next);
        chk({tag, ".ill"},   {31'd0, illegal}, {31'd0, e_ill});
    endtask

    // Wait (bounded) for ope_valid, check the instruction, then accept it.
    task automatic fetch_one(input string tag, input logic [31:0] e_ope,
                             input logic [3:0] e_num, input logic [31:0] e_next);
        int k;
        k = 0;
        while (!ope_valid && k < 12) begin
            tick();
            k++;
        end
        chk_instr(tag, e_ope, e_num, e_next, 1'b0);
        ope_ready = 1'b1;
        tick();
        ope_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] hold_ope;
        n_tests        = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        ope_ready      = 1'b0;
        eip_load       = 1'b0;
        eip_load_value = 32'd0;
        ack_en         = 1'b0;
        ack_force      = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h55; mem[8'h01] = 8'h89; mem[8'h02] = 8'he5; mem[8'h03] = 8'hc3;
        mem[8'h0a] = 8'he8; mem[8'h0b] = 8'hee; mem[8'h0c] = 8'hff;
        mem[8'h0d] = 8'hff; mem[8'h0e] = 8'hff;
        mem[8'h20] = 8'hb8; mem[8'h21] = 8'haa;
        mem[8'h40] = 8'h5d;
        mem[8'h60] = 8'hb8; mem[8'h61] = 8'h11; mem[8'h62] = 8'h22;
        mem[8'h63] = 8'h33; mem[8'h64] = 8'h44;
        mem[8'h80] = 8'h8b; mem[8'h81] = 8'h01; mem[8'h82] = 8'h02;
        mem[8'h83] = 8'h6a; mem[8'h84] = 8'h07;
        mem[8'h85] = 8'he2; mem[8'h86] = 8'hfe;
        mem[8'h87] = 8'h83; mem[8'h88] = 8'hc0; mem[8'h89] = 8'h04;
        mem[8'hff] = 8'h0f;

        // Reset state
        tick(); tick();
        chk("rst.req",   {31'd0, mem_req}, 32'd0);
        chk("rst.addr",  mem_addr, 32'd0);
        chk("rst.ope",   ope, 32'd0);
        chk("rst.num",   {28'd0, num_of_ope}, 32'd0);
        chk("rst.next",  next_eip, 32'd0);
        chk("rst.ill",   {31'd0, illegal}, 32'd0);
        chk("rst.valid", {31'd0, ope_valid}, 32'd0);

        // Back-to-back 55 / 89 e5 with ack every cycle and ready high
        ack_en = 1'b1; ope_ready = 1'b1;
        reset_n = 1'b1;
        chk("idle.req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("i1.req",  {31'd0, mem_req}, 32'd1);
        chk("i1.addr", mem_addr, 32'd0);
        tick();
        chk_instr("i1", 32'h55000000, 4'd1, 32'd1, 1'b0);
        chk("i1.preq", {31'd0, mem_req}, 32'd0);
        tick();
        chk("i2.addr0", mem_addr, 32'd1);
        chk("i2.nv0", {31'd0, ope_valid}, 32'd0);
        tick();
        chk("i2.addr1", mem_addr, 32'd2);
        tick();
        chk_instr("i2", 32'h89e50000, 4'd2, 32'd3, 1'b0);

        // Stall 7 cycles (with stray acks while mem_req is low), accept on 8th
        ope_ready = 1'b0; ack_en = 1'b0; ack_force = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("stall.valid", {31'd0, ope_valid}, 32'd1);
            chk("stall.ope",   ope, 32'h89e50000);
            chk("stall.next",  next_eip, 32'd3);
            chk("stall.req",   {31'd0, mem_req}, 32'd0);
        end
        ack_force = 1'b0;
        ope_ready = 1'b1;
        tick();
        ope_ready = 1'b0;
        chk("acc.addr", mem_addr, 32'd3);
        chk("acc.req",  {31'd0, mem_req}, 32'd1);
        chk("acc.nv",   {31'd0, ope_valid}, 32'd0);

        // Redirect to 10: call rel32, five bytes
        eip_load = 1'b1; eip_load_value = 32'd10;
        tick();
        eip_load = 1'b0;
        chk("ld10.req",  {31'd0, mem_req}, 32'd0);
        chk("ld10.addr", mem_addr, 32'd10);
        ack_en = 1'b1;
        for (int a = 0; a < 5; a++) begin
            tick();
            chk("e8.addr", mem_addr, 32'd10 + a);
            chk("e8.nv",   {31'd0, ope_valid}, 32'd0);
        end
        tick();
        chk_instr("e8", 32'he8eeffff, 4'd5, 32'd15, 1'b0);

        // Accept together with redirect to 0x20: target wins over next_eip
        ope_ready = 1'b1; eip_load = 1'b1; eip_load_value = 32'h20;
        tick();
        eip_load = 1'b0;
        chk("ldacc.addr",  mem_addr, 32'h20);
        chk("ldacc.req",   {31'd0, mem_req}, 32'd0);
        chk("ldacc.valid", {31'd0, ope_valid}, 32'd0);
        tick();
        chk("b8.addr0", mem_addr, 32'h20);
        tick();
        chk("b8.addr1", mem_addr, 32'h21);
        // Redirect during the 2nd byte of b8
        eip_load = 1'b1; eip_load_value = 32'h40;
        tick();
        eip_load = 1'b0;
        chk("ld40.addr",  mem_addr, 32'h40);
        chk("ld40.req",   {31'd0, mem_req}, 32'd0);
        chk("ld40.valid", {31'd0, ope_valid}, 32'd0);
        tick();
        chk("5d.addr", mem_addr, 32'h40);
        chk("5d.nv",   {31'd0, ope_valid}, 32'd0);
        tick();
        chk_instr("5d", 32'h5d000000, 4'd1, 32'h41, 1'b0);

        // Illegal opcode at the top of the address space
        ope_ready = 1'b0; eip_load = 1'b1; eip_load_value = 32'hffffffff;
        tick();
        eip_load = 1'b0;
        tick();
        chk("0f.addr", mem_addr, 32'hffffffff);
        tick();
        chk_instr("0f", 32'h0f000000, 4'd1, 32'd0, 1'b1);

        // Remaining length-table entries
        eip_load = 1'b1; eip_load_value = 32'h80;
        tick();
        eip_load = 1'b0;
        fetch_one("8b", 32'h8b010200, 4'd3, 32'h83);
        fetch_one("6a", 32'h6a070000, 4'd2, 32'h85);
        fetch_one("e2", 32'he2fe0000, 4'd2, 32'h87);
        fetch_one("83", 32'h83c00400, 4'd3, 32'h8a);

        // Reset pulsed in the middle of FETCH_REST
        eip_load = 1'b1; eip_load_value = 32'h60;
        tick();
        eip_load = 1'b0;
        tick();
        tick();
        tick();
        chk("mid.addr", mem_addr, 32'h62);
        hold_ope = ope;
        reset_n = 1'b0;
        #1;
        chk("arst.req",   {31'd0, mem_req}, 32'd0);
        chk("arst.addr",  mem_addr, 32'd0);
        chk("arst.ope",   ope, 32'd0);
        chk("arst.num",   {28'd0, num_of_ope}, 32'd0);
        chk("arst.next",  next_eip, 32'd0);
        chk("arst.valid", {31'd0, ope_valid}, 32'd0);
        tick();
        reset_n = 1'b1;
        chk("rel.req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("rel.req1",  {31'd0, mem_req}, 32'd1);
        chk("rel.addr1", mem_addr, 32'd0);
        tick();
        chk_instr("rel", 32'h55000000, 4'd1, 32'd1, 1'b0);
        if (hold_ope[31:24] !== 8'hb8) begin
            n_tests++;
            n_fail++;
            $display("FAIL mid.ope: got %08h expected b8xxxxxx", hold_ope);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 clock  in  1  single rising-edge clock for all state.
REQ-002 reset_n  in  1  reset, asynchronous, active-low.
REQ-003 mem_req  out  1  byte-read request; address valid while high.
REQ-004 mem_addr  out  32  byte address of the current read.
REQ-005 mem_ack  in  1  read complete this cycle; mem_data valid.
REQ-006 mem_data  in  8  read byte.
REQ-007 ope  out  32  instruction window: first byte [31:24], second [23:16], third [15:8], fourth [7:0].
REQ-008 num_of_ope  out  4  instruction length in bytes (1..5).
REQ-009 next_eip  out  32  address of the byte after the presented instruction.
REQ-010 illegal  out  1  presented first byte is not in the length table.
REQ-011 ope_valid  out  1  ope, num_of_ope, next_eip and illegal valid.
REQ-012 ope_ready  in  1  downstream ALU/sequencer accepts the instruction.
REQ-013 eip_load  in  1  redirect request (jump/call/ret/loop).
REQ-014 eip_load_value  in  32  redirect target byte address.

Function
REQ-015 Internal eip SHALL be a 32-bit byte pointer; mem_addr SHALL equal eip plus bytes already fetched for the current instruction.
REQ-016 FSM states: IDLE, FETCH_OP, FETCH_REST, PRESENT.
- IDLE -> FETCH_OP unconditionally.
- FETCH_OP: mem_req=1; on mem_ack, capture byte into ope[31:24], look up length, then go to PRESENT if length=1, else FETCH_REST.
- FETCH_REST: mem_req=1; each mem_ack captures one byte; on final ack go to PRESENT.
- PRESENT: ope_valid=1, mem_req=0; on ope_ready go to FETCH_OP with eip <= next_eip.
REQ-017 Length table: 55,5d,c3 -> 1; 89,6a,e2 -> 2; 8b,83 -> 3; b8,e8 -> 5; any other byte -> 1 with illegal=1.
REQ-018 Bytes 2..4 SHALL fill ope[23:16], [15:8], [7:0] in order; byte 5 SHALL be fetched and counted but not stored.
REQ-019 ope byte lanes beyond the instruction length SHALL be 8'h00.
REQ-020 next_eip SHALL equal eip + num_of_ope, modulo 2^32 (0xFFFFFFFF + 1 wraps to 0).
REQ-021 Throughput: one byte per cycle while mem_ack is held high; an n-byte instruction SHALL assert ope_valid in the cycle after its n-th ack.
REQ-022 ope, num_of_ope, next_eip and illegal SHALL remain stable while ope_valid=1 and ope_ready=0.
REQ-023 mem_ack while mem_req=0 SHALL be ignored.
REQ-024 eip_load SHALL have priority in every state: discard any partial or presented instruction, set eip <= eip_load_value, deassert mem_req and ope_valid in the next cycle, and enter FETCH_OP.
REQ-025 eip_load in the same cycle as ope_valid & ope_ready: the handshake SHALL count as accepted and the redirect SHALL still take effect; eip SHALL take eip_load_value, not next_eip.
REQ-026 mem_ack in the same cycle as eip_load: the byte SHALL be dropped.

Reset
REQ-027 While reset_n=0: state=IDLE, eip=0, ope=0, num_of_ope=0, next_eip=0, illegal=0, ope_valid=0, mem_req=0, mem_addr=0.
REQ-028 Reset asserted mid-fetch SHALL abandon the instruction immediately; after release, fetch SHALL restart at address 0 following one IDLE cycle.

Structure
REQ-029 Opcode constants (8'h55, 8'h89, 8'hb8, 8'h5d, 8'hc3, 8'he2, 8'he8, 8'h6a, 8'h8b, 8'h83) and the FSM state encoding SHALL live in shared package cpu_pkg, which the ALU also uses.
REQ-030 Length lookup SHALL be one combinational sub-module, inst_len_decode (8-bit opcode in; 4-bit length and illegal out).

Verification
REQ-031 Memory 0:55, 1:89, 2:e5, with ack every cycle and ope_ready=1 -> instruction 1: ope=55000000, num=1, next_eip=1; instruction 2: ope=89e50000, num=2, next_eip=3.
REQ-032 Memory 10:e8 ee ff ff ff at eip=10 -> ope=e8eeffff, num=5, next_eip=15; ope_valid one cycle after the 5th ack; mem_addr 10..14 in sequence.
REQ-033 ope_valid with ope_ready=0 for 7 cycles -> outputs stable, mem_req=0; accept on cycle 8 -> mem_addr=next_eip the following cycle.
REQ-034 eip_load=1, eip_load_value=0x40 during the 2nd byte of b8 -> partial instruction discarded; next mem_addr=0x40; no ope_valid for the b8 instruction.
REQ-035 Opcode 0x0f at eip=0xFFFFFFFF -> illegal=1, num=1, next_eip=0.
REQ-036 reset_n pulsed low mid-FETCH_REST -> all outputs 0; after release, one IDLE cycle, then mem_req=1 with mem_addr=0.
